// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_t : control FSM states (IDLE, RUN, DONE)
//   - maj3    : three-input majority, i.e. the carry of a full adder
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Operand and result handshakes of the bit-serial adder.
//   Operand side : valid_i, ready_o, a_i, b_i, cin_i
//   Result side  : valid_o, ready_i, sum_o, cout_o, ovf_o (ovf_o only when
//                  SERIAL_ADDER_OVF_EN is defined)
//   Modports: master = producer of operands / consumer of results,
//             slave  = the adder itself.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_o;
`endif

  modport master (
    output valid_i, a_i, b_i, cin_i, ready_i,
    input  ready_o, valid_o, sum_o, cout_o
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf_o
`endif
  );

  modport slave (
    input  valid_i, a_i, b_i, cin_i, ready_i,
    output ready_o, valid_o, sum_o, cout_o
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf_o
`endif
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit combinational full adder used by the serial adder datapath.
//   Ports: a, b, cin (inputs) -> s (sum), cout (carry-out).
// -----------------------------------------------------------------------------
module full_adder
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: latches two WIDTH-bit operands and a carry-in, then adds
//   them LSB-first, one bit per clock, through one full adder and a registered
//   carry. Result {cout_o, sum_o} = a + b + cin is offered on a valid/ready
//   handshake.
//   Ports:
//     clk_i : clock, posedge
//     rst_i : synchronous active-high reset
//     bus   : serial_adder_if.slave (operand and result handshakes)
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds ovf_o (signed overflow,
//   registered together with sum_o).
//   Timing: operands accepted on edge t, valid_o high from edge t+WIDTH,
//   ready_o back on the edge after the result is taken.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // control state
  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             c_q,     c_d;

  // datapath state
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,   ovf_d;
`endif

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          c_d     = bus.cin_i;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at
        // the LSB.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        sh_d  = (sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = sh_d;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last bit c_q is the carry into the MSB.
          ovf_d   = c_q ^ fa_c;
`endif
          valid_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    a_q  <= a_d;
    b_q  <= b_d;
    sh_q <= sh_d;
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.sum_o   = sum_q;
  assign bus.cout_o  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed testbench for serial_adder (WIDTH=8). Inputs change 1 time unit
//   after the rising edge; outputs are sampled at that same point.
//   Define SERIAL_ADDER_OVF_EN to also exercise ovf_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // Presents operands for one edge, then waits (bounded) for valid_o.
  // lat = number of edges from acceptance until valid_o is seen high.
  // If pulse_at >= 0, valid_i is re-asserted with 0xAA/0x55 for one cycle
  // after that many RUN edges.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input int pulse_at, output int lat);
    bus.valid_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.cin_i   = cin;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.a_i     = 8'hC3;   // operands may change freely after acceptance
    bus.b_i     = 8'h3C;
    bus.cin_i   = ~cin;
    lat = 0;
    while (!bus.valid_o && lat < 40) begin
      if (lat == pulse_at) begin
        bus.valid_i = 1'b1;
        bus.a_i     = 8'hAA;
        bus.b_i     = 8'h55;
      end else begin
        bus.valid_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic take_result();
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", bus.valid_o); end
    checks++; if (bus.sum_o !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h need 00", bus.sum_o); end
    checks++; if (bus.cout_o !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b need 0", bus.cout_o); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b need 0", bus.ovf_o); end
`endif
  endtask

  task automatic test_basic();
    int lat;
    run_op(8'h0F, 8'h01, 1'b0, -1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d need 8", lat); end
    checks++; if (bus.sum_o !== 8'h10) begin errors++; $display("FAIL basic_sum: got %h need 10", bus.sum_o); end
    checks++; if (bus.cout_o !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b need 0", bus.cout_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b need 0", bus.ready_o); end
    take_result();
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b need 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b need 0", bus.valid_o); end
  endtask

  task automatic test_carry();
    int lat;
    logic [7:0] av [3] = '{8'hFF, 8'hFF, 8'h3C};
    logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'hA5};
    logic       cv [3] = '{1'b0,  1'b1,  1'b1};
    logic [7:0] sv [3] = '{8'h00, 8'hFF, 8'hE2};
    logic       ov [3] = '{1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], cv[i], -1, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL carry_latency[%0d]: got %0d need 8", i, lat); end
      checks++; if (bus.sum_o !== sv[i]) begin errors++; $display("FAIL carry_sum[%0d]: got %h need %h", i, bus.sum_o, sv[i]); end
      checks++; if (bus.cout_o !== ov[i]) begin errors++; $display("FAIL carry_cout[%0d]: got %b need %b", i, bus.cout_o, ov[i]); end
      take_result();
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(8'h7F, 8'h01, 1'b0, -1, lat);
    checks++; if (bus.sum_o !== 8'h80) begin errors++; $display("FAIL ovf_sum: got %h need 80", bus.sum_o); end
    checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b need 1", bus.ovf_o); end
    take_result();
    run_op(8'hFF, 8'h01, 1'b0, -1, lat);
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b need 0", bus.ovf_o); end
    checks++; if (bus.cout_o !== 1'b1) begin errors++; $display("FAIL ovf_cout: got %b need 1", bus.cout_o); end
    take_result();
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    run_op(8'h12, 8'h34, 1'b0, -1, lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b need 1", i, bus.valid_o); end
      checks++; if (bus.sum_o !== 8'h46) begin errors++; $display("FAIL bp_sum[%0d]: got %h need 46", i, bus.sum_o); end
      @(posedge clk); #1;
    end
    take_result();
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b need 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b need 0", bus.valid_o); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    // Last completed result is 0x46, so a cleared sum_o is observable.
    bus.valid_i = 1'b1;
    bus.a_i     = 8'h55;
    bus.b_i     = 8'h0A;
    bus.cin_i   = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;           // lands on the 4th RUN edge
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstrun_ready: got %b need 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstrun_valid: got %b need 0", bus.valid_o); end
    checks++; if (bus.sum_o !== 8'h00) begin errors++; $display("FAIL rstrun_sum: got %h need 00", bus.sum_o); end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstrun_no_result: got %0d valid cycles need 0", seen); end
    run_op(8'h03, 8'h04, 1'b0, -1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL rstrun_next_latency: got %0d need 8", lat); end
    checks++; if (bus.sum_o !== 8'h07) begin errors++; $display("FAIL rstrun_next_sum: got %h need 07", bus.sum_o); end
    checks++; if (bus.cout_o !== 1'b0) begin errors++; $display("FAIL rstrun_next_cout: got %b need 0", bus.cout_o); end
    take_result();
  endtask

  task automatic test_valid_ignored();
    int lat;
    run_op(8'h21, 8'h10, 1'b0, 3, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ign_latency: got %0d need 8", lat); end
    checks++; if (bus.sum_o !== 8'h31) begin errors++; $display("FAIL ign_sum: got %h need 31", bus.sum_o); end
    checks++; if (bus.cout_o !== 1'b0) begin errors++; $display("FAIL ign_cout: got %b need 0", bus.cout_o); end
    take_result();
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL ign_ready_after: got %b need 1", bus.ready_o); end
  endtask

  task automatic test_back_to_back();
    int lat;
    // New operands presented on the very edge ready_o returns.
    run_op(8'h80, 8'h80, 1'b1, -1, lat);
    checks++; if ({bus.cout_o, bus.sum_o} !== 9'h101) begin errors++; $display("FAIL b2b_first: got %h need 101", {bus.cout_o, bus.sum_o}); end
    take_result();
    run_op(8'h01, 8'h02, 1'b1, -1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d need 8", lat); end
    checks++; if ({bus.cout_o, bus.sum_o} !== 9'h004) begin errors++; $display("FAIL b2b_second: got %h need 004", {bus.cout_o, bus.sum_o}); end
    take_result();
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.cin_i   = 1'b0;
    bus.ready_i = 1'b0;
    test_reset();
    test_basic();
    test_carry();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_backpressure();
    test_reset_mid_run();
    test_valid_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
